// File: rtl/sprite_line_engine_pkg.sv
// Shared types and constants for the sprite line engine: attribute field codes,
// FSM states and the attribute record layout.
package sprite_line_engine_pkg;

    localparam int unsigned LINE_PIXELS = 256;
    localparam int unsigned SPRITE_SIZE = 8;

    localparam logic [1:0] ATTR_NUM = 2'd0;
    localparam logic [1:0] ATTR_X   = 2'd1;
    localparam logic [1:0] ATTR_Y   = 2'd2;
    localparam logic [1:0] ATTR_EN  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StEval,
        StFetch,
        StDrain,
        StDone
    } line_state_e;

    typedef struct packed {
        logic [5:0] num;
        logic [7:0] x;
        logic [7:0] y;
        logic       en;
    } sprite_attr_t;

    // Row of the sprite that lands on the requested line (8-bit modulo).
    function automatic logic [7:0] row_offset(input logic [7:0] line_y, input logic [7:0] y);
        return line_y - y;
    endfunction

    function automatic logic is_hit(input sprite_attr_t attr, input logic [7:0] dy);
        return attr.en && (dy < 8'(SPRITE_SIZE));
    endfunction

endpackage

// File: rtl/sprite_attr_table.sv
// Motion-sprite attribute register file: one field written per strobe,
// whole record read combinationally by index.
module sprite_attr_table
    import sprite_line_engine_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned IDX_W       = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [1:0]       field,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] ridx,
    output sprite_attr_t     rdata
);

    sprite_attr_t table_q [NUM_SPRITES];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                table_q[i] <= '0;
            end
        end else if (we) begin
            unique case (field)
                ATTR_NUM: table_q[widx].num <= wdata[5:0];
                ATTR_X:   table_q[widx].x   <= wdata;
                ATTR_Y:   table_q[widx].y   <= wdata;
                ATTR_EN:  table_q[widx].en  <= wdata[0];
                default:  ;
            endcase
        end
    end

    assign rdata = table_q[ridx];

endmodule

// File: rtl/sprite_line_engine.sv
// Builds one scanline into the write half of the ping-pong line buffer: clear,
// then walk sprites from the highest index down so lower indices overwrite.
module sprite_line_engine
    import sprite_line_engine_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned IDX_W       = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             line_start,
    input  logic [7:0]       line_y,
    input  logic             bank,
    input  logic             attr_we,
    input  logic [IDX_W-1:0] attr_idx,
    input  logic [1:0]       attr_field,
    input  logic [7:0]       attr_wdata,
    output logic [5:0]       rom_sprite_num,
    output logic [2:0]       rom_row,
    output logic [2:0]       rom_col,
    input  logic [1:0]       rom_pixel,
    output logic             lb_write,
    output logic [8:0]       lb_addr,
    output logic [1:0]       lb_data,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam logic [2:0] LastCol  = 3'(SPRITE_SIZE - 1);
    localparam logic [7:0] LastAddr = 8'(LINE_PIXELS - 1);

    line_state_e      state_q;
    logic [7:0]       line_y_q;
    logic             bank_q;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       col_q;
    logic [7:0]       spr_x_q;
    logic [7:0]       clr_addr_q;
    logic             clr_we_q;
    logic             wr_pend_q;
    logic             wr_clip_q;
    logic [7:0]       wr_x_q;

    sprite_attr_t     cur_attr;
    logic [7:0]       cur_dy;
    logic             cur_hit;
    logic [8:0]       pix_x;

    sprite_attr_table #(
        .NUM_SPRITES (NUM_SPRITES),
        .IDX_W       (IDX_W)
    ) u_attr_table (
        .clock (clock),
        .reset (reset),
        .we    (attr_we),
        .widx  (attr_idx),
        .field (attr_field),
        .wdata (attr_wdata),
        .ridx  (idx_q),
        .rdata (cur_attr)
    );

    assign cur_dy  = row_offset(line_y_q, cur_attr.y);
    assign cur_hit = is_hit(cur_attr, cur_dy);
    // 9-bit sum so pixels past the right edge are clipped rather than wrapped.
    assign pix_x   = {1'b0, spr_x_q} + {6'b0, col_q};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= StIdle;
            line_y_q       <= '0;
            bank_q         <= 1'b0;
            idx_q          <= '0;
            col_q          <= '0;
            spr_x_q        <= '0;
            clr_addr_q     <= '0;
            clr_we_q       <= 1'b0;
            wr_pend_q      <= 1'b0;
            wr_clip_q      <= 1'b0;
            wr_x_q         <= '0;
            rom_sprite_num <= '0;
            rom_row        <= '0;
            rom_col        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            wr_pend_q <= 1'b0;
            if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (line_start) begin
                // A restart abandons the current build; set beats clear.
                if (state_q != StIdle) begin
                    overrun <= 1'b1;
                end
                line_y_q   <= line_y;
                bank_q     <= bank;
                clr_addr_q <= '0;
                clr_we_q   <= 1'b1;
                busy       <= 1'b1;
                done       <= 1'b0;
                state_q    <= StClear;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StClear: begin
                        if (clr_addr_q == LastAddr) begin
                            clr_we_q <= 1'b0;
                            idx_q    <= IDX_W'(NUM_SPRITES - 1);
                            state_q  <= StEval;
                        end else begin
                            clr_addr_q <= clr_addr_q + 8'd1;
                        end
                    end
                    StEval: begin
                        if (cur_hit) begin
                            rom_sprite_num <= cur_attr.num;
                            rom_row        <= cur_dy[2:0];
                            rom_col        <= '0;
                            col_q          <= '0;
                            spr_x_q        <= cur_attr.x;
                            state_q        <= StFetch;
                        end else if (idx_q == '0) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q - IDX_W'(1);
                        end
                    end
                    StFetch: begin
                        wr_pend_q <= 1'b1;
                        wr_x_q    <= pix_x[7:0];
                        wr_clip_q <= pix_x[8];
                        if (col_q == LastCol) begin
                            state_q <= StDrain;
                        end else begin
                            col_q   <= col_q + 3'd1;
                            rom_col <= col_q + 3'd1;
                        end
                    end
                    StDrain: begin
                        if (idx_q == '0) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q - IDX_W'(1);
                            state_q <= StEval;
                        end
                    end
                    StDone: begin
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // ROM data arrives the cycle after its address, so sprite writes use it directly.
    assign lb_write = clr_we_q | (wr_pend_q & ~wr_clip_q & (rom_pixel != 2'b00));
    assign lb_addr  = wr_pend_q ? {bank_q, wr_x_q} : {bank_q, clr_addr_q};
    assign lb_data  = wr_pend_q ? rom_pixel : 2'b00;

endmodule

// File: tb/tb_sprite_line_engine.sv
// Self-checking bench for sprite_line_engine: a line-level reference model
// predicts the ordered buffer writes and completion cycle of each build.
module tb_sprite_line_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       line_start = 1'b0;
    logic [7:0] line_y = 8'd0;
    logic       bank = 1'b0;
    logic       attr_we = 1'b0;
    logic [2:0] attr_idx = 3'd0;
    logic [1:0] attr_field = 2'd0;
    logic [7:0] attr_wdata = 8'd0;
    logic [1:0] rom_pixel = 2'd0;
    logic       overrun_clr = 1'b0;
    logic [5:0] rom_sprite_num;
    logic [2:0] rom_row;
    logic [2:0] rom_col;
    logic       lb_write;
    logic [8:0] lb_addr;
    logic [1:0] lb_data;
    logic       busy;
    logic       done;
    logic       overrun;

    sprite_line_engine #(
        .NUM_SPRITES (8),
        .IDX_W       (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .line_start     (line_start),
        .line_y         (line_y),
        .bank           (bank),
        .attr_we        (attr_we),
        .attr_idx       (attr_idx),
        .attr_field     (attr_field),
        .attr_wdata     (attr_wdata),
        .rom_sprite_num (rom_sprite_num),
        .rom_row        (rom_row),
        .rom_col        (rom_col),
        .rom_pixel      (rom_pixel),
        .lb_write       (lb_write),
        .lb_addr        (lb_addr),
        .lb_data        (lb_data),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr)
    );

    always #5 clock = ~clock;

    logic [1:0] rom_mem [4096];
    always @(posedge clock) rom_pixel <= rom_mem[{rom_sprite_num, rom_row, rom_col}];

    int checks = 0;
    int failures = 0;

    logic [5:0] s_num [8];
    logic [7:0] s_x [8];
    logic [7:0] s_y [8];
    logic       s_en [8];
    logic [1:0] lbuf [512];
    logic [10:0] wq[$];
    logic [10:0] eq[$];
    int bad_busy;
    int mw_cycle = 0;
    logic [2:0] mw_idx;
    logic [1:0] mw_field;
    logic [7:0] mw_data;
    logic [5:0] rlog_num [512];
    logic [2:0] rlog_row [512];
    logic [2:0] rlog_col [512];

    task automatic clear_shadow();
        for (int i = 0; i < 8; i++) begin
            s_num[i] = 6'd0; s_x[i] = 8'd0; s_y[i] = 8'd0; s_en[i] = 1'b0;
        end
    endtask

    task automatic shadow_write(input logic [2:0] i, input logic [1:0] f, input logic [7:0] d);
        case (f)
            2'd0: s_num[i] = d[5:0];
            2'd1: s_x[i] = d;
            2'd2: s_y[i] = d;
            default: s_en[i] = d[0];
        endcase
    endtask

    task automatic write_attr(input logic [2:0] i, input logic [1:0] f, input logic [7:0] d);
        @(negedge clock);
        attr_we = 1'b1; attr_idx = i; attr_field = f; attr_wdata = d;
        @(negedge clock);
        attr_we = 1'b0;
        shadow_write(i, f, d);
    endtask

    task automatic set_sprite(input logic [2:0] i, input logic [5:0] num, input logic [7:0] x,
                              input logic [7:0] y, input logic en);
        write_attr(i, 2'd0, {2'b00, num});
        write_attr(i, 2'd1, x);
        write_attr(i, 2'd2, y);
        write_attr(i, 2'd3, {7'd0, en});
    endtask

    // Returns at the negedge of cycle 1 (the first cycle after line_start is sampled).
    task automatic start_line(input logic [7:0] ly, input logic bk, input logic clr);
        @(negedge clock);
        line_start = 1'b1; line_y = ly; bank = bk; overrun_clr = clr;
        @(negedge clock);
        line_start = 1'b0; overrun_clr = 1'b0;
        line_y = 8'($urandom); bank = 1'($urandom);
    endtask

    task automatic collect(output int done_at);
        int k;
        wq.delete();
        done_at = -1;
        bad_busy = 0;
        k = 1;
        forever begin
            attr_we = 1'b0;
            if (mw_cycle != 0 && k == mw_cycle) begin
                attr_we = 1'b1; attr_idx = mw_idx; attr_field = mw_field; attr_wdata = mw_data;
                shadow_write(mw_idx, mw_field, mw_data);
            end
            if (k < 512) begin
                rlog_num[k] = rom_sprite_num; rlog_row[k] = rom_row; rlog_col[k] = rom_col;
            end
            if (lb_write === 1'b1) wq.push_back({lb_addr, lb_data});
            if (busy !== 1'b1) bad_busy++;
            if (done === 1'b1) begin
                done_at = k;
                break;
            end
            if (k >= 400) break;
            @(negedge clock);
            k++;
        end
        attr_we = 1'b0;
        mw_cycle = 0;
    endtask

    // Reference: clear the half, then draw enabled sprites from index 7 down to 0.
    task automatic build_model(input logic [7:0] ly, input logic bk, output int cyc);
        int hits;
        logic [7:0] dy;
        logic [1:0] p;
        eq.delete();
        for (int n = 0; n < 256; n++) eq.push_back({bk, 8'(n), 2'b00});
        hits = 0;
        for (int i = 7; i >= 0; i--) begin
            dy = ly - s_y[i];
            if (s_en[i] && dy < 8) begin
                hits++;
                for (int c = 0; c < 8; c++) begin
                    p = rom_mem[{s_num[i], dy[2:0], 3'(c)}];
                    if (p != 2'b00 && int'(s_x[i]) + c <= 255)
                        eq.push_back({bk, 8'(int'(s_x[i]) + c), p});
                end
            end
        end
        cyc = 256 + 8 + 9 * hits + 1;
    endtask

    task automatic check_line(input string name, input logic [7:0] ly, input logic bk,
                              input int done_at);
        int exp_cyc;
        int first_bad;
        int n;
        build_model(ly, bk, exp_cyc);
        foreach (wq[i]) lbuf[wq[i][10:2]] = wq[i][1:0];
        checks++;
        if (wq.size() != eq.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wq.size(), eq.size());
        end
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        first_bad = -1;
        for (int i = 0; i < n; i++) if (first_bad < 0 && wq[i] !== eq[i]) first_bad = i;
        checks++;
        if (first_bad >= 0) begin
            failures++;
            $display("FAIL %s write_seq[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
                     name, first_bad, wq[first_bad][10:2], wq[first_bad][1:0],
                     eq[first_bad][10:2], eq[first_bad][1:0]);
        end
        checks++;
        if (done_at != exp_cyc) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, exp_cyc);
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL %s busy_during_build: %0d cycles low, expected 0", name, bad_busy);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: busy=%b done=%b expected 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, lb_write, overrun} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, lb_write, overrun});
        end
        checks++;
        if (lb_addr !== 9'd0 || lb_data !== 2'd0) begin
            failures++;
            $display("FAIL reset_lb: got addr=%0d data=%0d expected 0 0", lb_addr, lb_data);
        end
        checks++;
        if ({rom_sprite_num, rom_row, rom_col} !== 12'd0) begin
            failures++;
            $display("FAIL reset_rom: got %h expected 000", {rom_sprite_num, rom_row, rom_col});
        end
        reset = 1'b1;
        clear_shadow();
    endtask

    task automatic test_clear_only();
        int d;
        start_line(8'd10, 1'b1, 1'b0);
        collect(d);
        check_line("clear_only", 8'd10, 1'b1, d);
        checks++;
        if (d != 265) begin
            failures++;
            $display("FAIL clear_only_latency: got %0d expected 265", d);
        end
    endtask

    task automatic test_single_sprite();
        int d;
        int bad;
        int ex [6] = '{21, 22, 23, 25, 26, 27};
        int ed [6] = '{1, 2, 3, 3, 2, 1};
        int pat [8] = '{0, 1, 2, 3, 0, 3, 2, 1};
        for (int c = 0; c < 8; c++) rom_mem[{6'd1, 3'd2, 3'(c)}] = 2'(pat[c]);
        set_sprite(3'd0, 6'd1, 8'd20, 8'd5, 1'b1);
        start_line(8'd7, 1'b0, 1'b0);
        collect(d);
        check_line("single", 8'd7, 1'b0, d);
        checks++;
        if (d != 274) begin
            failures++;
            $display("FAIL single_latency: got %0d expected 274", d);
        end
        bad = 0;
        if (wq.size() != 262) bad++;
        else for (int j = 0; j < 6; j++)
            if (wq[256 + j] !== {1'b0, 8'(ex[j]), 2'(ed[j])}) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_pixels: got %0d wrong entries (of %0d writes) expected 0",
                     bad, wq.size());
        end
        bad = 0;
        for (int k = 265; k <= 272; k++)
            if (rlog_col[k] !== 3'(k - 265) || rlog_row[k] !== 3'd2 || rlog_num[k] !== 6'd1) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_rom_addr: got %0d bad fetch cycles expected 0", bad);
        end
    endtask

    task automatic test_priority();
        int d;
        int bad;
        for (int c = 0; c < 8; c++) begin
            rom_mem[{6'd2, 3'd0, 3'(c)}] = 2'($urandom_range(1, 3));
            rom_mem[{6'd3, 3'd0, 3'(c)}] = 2'($urandom_range(1, 3));
        end
        set_sprite(3'd3, 6'd2, 8'd40, 8'd0, 1'b1);
        set_sprite(3'd0, 6'd3, 8'd40, 8'd0, 1'b1);
        start_line(8'd0, 1'b1, 1'b0);
        collect(d);
        check_line("priority", 8'd0, 1'b1, d);
        bad = 0;
        for (int c = 0; c < 8; c++)
            if (lbuf[{1'b1, 8'(40 + c)}] !== rom_mem[{6'd3, 3'd0, 3'(c)}]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL priority_winner: got %0d pixels not from sprite 0 expected 0", bad);
        end
    endtask

    task automatic test_clip();
        int d;
        int n_right;
        int n_other;
        write_attr(3'd0, 2'd3, 8'd0);
        write_attr(3'd3, 2'd3, 8'd0);
        for (int c = 0; c < 8; c++) rom_mem[{6'd4, 3'd0, 3'(c)}] = 2'($urandom_range(1, 3));
        set_sprite(3'd5, 6'd4, 8'd252, 8'd0, 1'b1);
        start_line(8'd0, 1'b0, 1'b0);
        collect(d);
        check_line("clip", 8'd0, 1'b0, d);
        n_right = 0; n_other = 0;
        for (int i = 256; i < wq.size(); i++)
            if (wq[i][9:2] >= 8'd252) n_right++; else n_other++;
        checks++;
        if (n_right != 4 || n_other != 0) begin
            failures++;
            $display("FAIL clip_edge: got right=%0d wrapped=%0d expected 4 0", n_right, n_other);
        end
        write_attr(3'd5, 2'd2, 8'd250);
        start_line(8'd2, 1'b1, 1'b0);
        collect(d);
        check_line("dy8_miss", 8'd2, 1'b1, d);
        checks++;
        if (d != 265) begin
            failures++;
            $display("FAIL dy8_latency: got %0d expected 265", d);
        end
        start_line(8'd255, 1'b0, 1'b0);
        collect(d);
        check_line("dy5_hit", 8'd255, 1'b0, d);
        checks++;
        if (d != 274) begin
            failures++;
            $display("FAIL dy5_latency: got %0d expected 274", d);
        end
    endtask

    task automatic test_overrun();
        int d;
        logic saw_done;
        start_line(8'd255, 1'b1, 1'b0);
        saw_done = 1'b0;
        repeat (98) begin
            @(negedge clock);
            if (done === 1'b1) saw_done = 1'b1;
        end
        start_line(8'd3, 1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1 || saw_done) begin
            failures++;
            $display("FAIL overrun_set: got overrun=%b early_done=%b expected 1 0", overrun, saw_done);
        end
        collect(d);
        check_line("overrun_restart", 8'd3, 1'b0, d);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got %b expected 1", overrun);
        end
        @(negedge clock); overrun_clr = 1'b1;
        @(negedge clock); overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got %b expected 0", overrun);
        end
        start_line(8'd7, 1'b1, 1'b0);
        repeat (20) @(negedge clock);
        start_line(8'd254, 1'b0, 1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set_wins: got %b expected 1", overrun);
        end
        collect(d);
        check_line("overrun_restart2", 8'd254, 1'b0, d);
        @(negedge clock); overrun_clr = 1'b1;
        @(negedge clock); overrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int d;
        write_attr(3'd5, 2'd3, 8'd0);
        set_sprite(3'd0, 6'd1, 8'd100, 8'd0, 1'b1);
        start_line(8'd3, 1'b1, 1'b0);
        repeat (266) @(negedge clock);
        checks++;
        if (rom_col !== 3'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_fetch_state: got col=%0d busy=%b expected 2 1", rom_col, busy);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (lb_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got write=%b busy=%b done=%b expected 0 0 0",
                     lb_write, busy, done);
        end
        reset = 1'b1;
        clear_shadow();
        start_line(8'd3, 1'b1, 1'b0);
        collect(d);
        check_line("after_reset", 8'd3, 1'b1, d);
        checks++;
        if (d != 265) begin
            failures++;
            $display("FAIL after_reset_latency: got %0d expected 265", d);
        end
    endtask

    task automatic test_random();
        int d;
        logic [7:0] ly;
        logic bk;
        for (int it = 0; it < 6; it++) begin
            ly = 8'($urandom);
            bk = 1'($urandom);
            for (int i = 0; i < 8; i++)
                set_sprite(3'(i), 6'($urandom), 8'($urandom), ly - 8'($urandom_range(0, 12)),
                           $urandom_range(0, 3) != 0);
            mw_idx = 3'($urandom);
            mw_field = 2'($urandom);
            mw_data = 8'($urandom);
            mw_cycle = $urandom_range(5, 240);
            start_line(ly, bk, 1'b0);
            collect(d);
            check_line("random", ly, bk, d);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 2'($urandom);
        for (int i = 0; i < 512; i++) lbuf[i] = 2'd0;
        clear_shadow();
        test_reset();
        test_clear_only();
        test_single_sprite();
        test_priority();
        test_clip();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
